// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the Y86 fetch stage: icodes, status codes,
// FSM encodings and the field values of a pipeline bubble.
package fetch_stage_pkg;

    localparam int DATA_WID_DEF = 32;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    // "No register" specifier
    localparam logic [3:0] RNONE = 4'hF;

    // Pipeline status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } fetch_state_e;

    // Bubble (NOP) contents of the D register
    localparam logic [3:0] BUBBLE_ICODE = I_NOP;
    localparam logic [3:0] BUBBLE_IFUN  = 4'h0;
    localparam logic [3:0] BUBBLE_REG   = RNONE;
    localparam logic [2:0] BUBBLE_STAT  = STAT_AOK;

    // Status of a fetched instruction: address error beats invalid icode beats halt
    function automatic logic [2:0] fetch_stat_f(input logic err, input logic [3:0] icode);
        logic [2:0] st;
        if (err)                 st = STAT_ADR;
        else if (icode > I_POPL) st = STAT_INS;
        else if (icode == I_HALT) st = STAT_HLT;
        else                     st = STAT_AOK;
        return st;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage <-> instruction-memory bus.
// Protocol: no handshake. The fetch stage presents f_pc combinationally and
// the memory answers with the decoded fields in the same cycle; imem_err
// flags an out-of-range f_pc. The master modport is the fetch stage.
interface fetch_stage_if #(
    parameter int DATA_WID = 32
);
    logic [DATA_WID-1:0] f_pc;
    logic [3:0]          imem_icode;
    logic [3:0]          imem_ifun;
    logic [3:0]          imem_rA;
    logic [3:0]          imem_rB;
    logic [DATA_WID-1:0] imem_valC;
    logic                imem_err;

    modport master (
        output f_pc,
        input  imem_icode, imem_ifun, imem_rA, imem_rB, imem_valC, imem_err
    );

    modport slave (
        input  f_pc,
        output imem_icode, imem_ifun, imem_rA, imem_rB, imem_valC, imem_err
    );
endinterface

// File: rtl/fetch_stage_len_calc.sv
// Instruction length decode: which optional bytes an icode carries and the
// resulting fall-through address valP (wraps silently).
module fetch_len_calc
    import fetch_stage_pkg::*;
#(
    parameter int DATA_WID = DATA_WID_DEF
) (
    input  logic [3:0]          icode,
    input  logic [DATA_WID-1:0] f_pc,
    output logic                need_regids,
    output logic                need_valc,
    output logic [DATA_WID-1:0] valp
);

    // Decode optional byte groups and add up the instruction length
    always_comb begin
        need_regids = icode inside {I_RRMOVL, I_IRMOVL, I_RMMOVL, I_MRMOVL,
                                    I_OPL, I_PUSHL, I_POPL};
        need_valc   = icode inside {I_IRMOVL, I_RMMOVL, I_MRMOVL, I_JXX, I_CALL};
        valp        = f_pc + DATA_WID'(1) + DATA_WID'(need_regids)
                    + (need_valc ? DATA_WID'(DATA_WID / 8) : '0);
    end

endmodule

// File: rtl/fetch_stage.sv
// Y86 pipelined fetch stage: predicted-PC register, RUN/RET_WAIT/HALTED
// control FSM, next-PC selection and the F/D pipeline register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  DATA_WID = DATA_WID_DEF,
    parameter logic [DATA_WID-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                f_stall,
    input  logic                d_stall,
    input  logic                d_bubble,
    input  logic                mispredict,
    input  logic [DATA_WID-1:0] mispredict_pc,
    input  logic                ret_valid,
    input  logic [DATA_WID-1:0] ret_pc,
    fetch_stage_if.master       imem,
    output logic [3:0]          d_icode,
    output logic [3:0]          d_ifun,
    output logic [3:0]          d_rA,
    output logic [3:0]          d_rB,
    output logic [DATA_WID-1:0] d_valC,
    output logic [DATA_WID-1:0] d_valP,
    output logic [2:0]          d_stat,
    output logic [1:0]          f_state
);

    fetch_state_e        state_q, state_d;
    logic [DATA_WID-1:0] pred_pc_q, pred_pc_d;
    logic [3:0]          d_icode_q, d_icode_d;
    logic [3:0]          d_ifun_q, d_ifun_d;
    logic [3:0]          d_ra_q, d_ra_d;
    logic [3:0]          d_rb_q, d_rb_d;
    logic [DATA_WID-1:0] d_valc_q, d_valc_d;
    logic [DATA_WID-1:0] d_valp_q, d_valp_d;
    logic [2:0]          d_stat_q, d_stat_d;

    logic [DATA_WID-1:0] f_pc_w;
    logic [DATA_WID-1:0] valp_w;
    logic                need_regids_w;
    logic                need_valc_w;
    logic [2:0]          f_stat_w;
    logic                fetch_live;

    fetch_len_calc #(.DATA_WID(DATA_WID)) u_len_calc (
        .icode       (imem.imem_icode),
        .f_pc        (f_pc_w),
        .need_regids (need_regids_w),
        .need_valc   (need_valc_w),
        .valp        (valp_w)
    );

    // PC selection; a halted stage ignores redirects entirely.
    // fetch_live marks cycles whose fetch is a real RUN-style fetch.
    always_comb begin
        f_pc_w     = pred_pc_q;
        fetch_live = 1'b0;
        if (state_q != ST_HALTED && mispredict) begin
            f_pc_w = mispredict_pc;
        end else if (state_q == ST_RET_WAIT && ret_valid) begin
            f_pc_w = ret_pc;
        end
        if (state_q == ST_RUN) begin
            fetch_live = 1'b1;
        end else if (state_q == ST_RET_WAIT) begin
            fetch_live = mispredict || ret_valid;
        end
        f_stat_w = fetch_stat_f(imem.imem_err, imem.imem_icode);
    end

    assign imem.f_pc = f_pc_w;

    // Next predicted PC and FSM state; both freeze while the fetch is not live
    always_comb begin
        pred_pc_d = pred_pc_q;
        state_d   = state_q;
        if (fetch_live && !f_stall) begin
            if (imem.imem_icode == I_JXX || imem.imem_icode == I_CALL) begin
                pred_pc_d = imem.imem_valC;
            end else begin
                pred_pc_d = valp_w;
            end
        end
        // Under any stall the same instruction is refetched, so hold the state
        if (fetch_live && !f_stall && !d_stall) begin
            if (imem.imem_icode == I_RET) begin
                state_d = ST_RET_WAIT;
            end else if (f_stat_w != STAT_AOK) begin
                state_d = ST_HALTED;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    // F/D register next value: halted forces bubbles, stall beats bubble
    always_comb begin
        d_icode_d = d_icode_q;
        d_ifun_d  = d_ifun_q;
        d_ra_d    = d_ra_q;
        d_rb_d    = d_rb_q;
        d_valc_d  = d_valc_q;
        d_valp_d  = d_valp_q;
        d_stat_d  = d_stat_q;
        if (state_q == ST_HALTED || (!d_stall && (d_bubble || !fetch_live))) begin
            d_icode_d = BUBBLE_ICODE;
            d_ifun_d  = BUBBLE_IFUN;
            d_ra_d    = BUBBLE_REG;
            d_rb_d    = BUBBLE_REG;
            d_valc_d  = '0;
            d_valp_d  = '0;
            d_stat_d  = BUBBLE_STAT;
        end else if (!d_stall) begin
            d_icode_d = imem.imem_icode;
            d_ifun_d  = imem.imem_ifun;
            d_ra_d    = imem.imem_rA;
            d_rb_d    = imem.imem_rB;
            d_valc_d  = imem.imem_valC;
            d_valp_d  = valp_w;
            d_stat_d  = f_stat_w;
        end
    end

    // FSM, F register and F/D register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pred_pc_q <= RESET_PC;
            d_icode_q <= BUBBLE_ICODE;
            d_ifun_q  <= BUBBLE_IFUN;
            d_ra_q    <= BUBBLE_REG;
            d_rb_q    <= BUBBLE_REG;
            d_valc_q  <= '0;
            d_valp_q  <= '0;
            d_stat_q  <= BUBBLE_STAT;
        end else begin
            state_q   <= state_d;
            pred_pc_q <= pred_pc_d;
            d_icode_q <= d_icode_d;
            d_ifun_q  <= d_ifun_d;
            d_ra_q    <= d_ra_d;
            d_rb_q    <= d_rb_d;
            d_valc_q  <= d_valc_d;
            d_valp_q  <= d_valp_d;
            d_stat_q  <= d_stat_d;
        end
    end

    assign d_icode = d_icode_q;
    assign d_ifun  = d_ifun_q;
    assign d_rA    = d_ra_q;
    assign d_rB    = d_rb_q;
    assign d_valC  = d_valc_q;
    assign d_valP  = d_valp_q;
    assign d_stat  = d_stat_q;
    assign f_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk through fetch/branch/ret/halt/stall
// scenarios followed by randomized traffic, all checked against a
// behavioural model of the stage kept here.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        f_stall = 1'b0, d_stall = 1'b0, d_bubble = 1'b0;
    logic        mispredict = 1'b0, ret_valid = 1'b0;
    logic [31:0] mispredict_pc = '0, ret_pc = '0;
    logic [3:0]  d_icode, d_ifun, d_rA, d_rB;
    logic [31:0] d_valC, d_valP;
    logic [2:0]  d_stat;
    logic [1:0]  f_state;

    fetch_stage_if #(.DATA_WID(32)) bus ();

    fetch_stage #(.DATA_WID(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .f_stall(f_stall), .d_stall(d_stall),
        .d_bubble(d_bubble), .mispredict(mispredict), .mispredict_pc(mispredict_pc),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .imem(bus),
        .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB),
        .d_valC(d_valC), .d_valP(d_valP), .d_stat(d_stat), .f_state(f_state)
    );

    // ---------------- reference model ----------------
    // mode: 0 running, 1 waiting for a return address, 2 halted
    int          m_mode;
    bit          m_valid = 1'b0;
    logic [31:0] m_pred;
    logic [3:0]  m_icode, m_ifun, m_ra, m_rb;
    logic [31:0] m_valc, m_valp;
    logic [2:0]  m_stat;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int instr_len(input logic [3:0] ic);
        int n;
        n = 1;
        if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) n += 1;
        if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) n += 4;
        return n;
    endfunction

    function automatic logic [2:0] exp_stat(input logic err, input logic [3:0] ic);
        if (err) return 3'd3;
        if (ic > 4'hB) return 3'd4;
        if (ic == 4'h0) return 3'd2;
        return 3'd1;
    endfunction

    task automatic model_bubble();
        m_icode = 4'h1; m_ifun = 4'h0; m_ra = 4'hF; m_rb = 4'hF;
        m_valc = '0; m_valp = '0; m_stat = 3'd1;
    endtask

    // ---------------- driver ----------------
    task automatic set_imem(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                            input logic [3:0] rb, input logic [31:0] vc, input logic err);
        bus.imem_icode = ic; bus.imem_ifun = fn; bus.imem_rA = ra;
        bus.imem_rB = rb; bus.imem_valC = vc; bus.imem_err = err;
    endtask

    // One clock: check f_pc before the edge, advance the model, check D after it
    task automatic cycle();
        logic [31:0] fpc, valp, n_pred;
        logic [2:0]  st;
        bit          live;
        int          n_mode;
        bit          load_bubble, load_fetch;
        #2;
        if (m_mode != 2 && mispredict) fpc = mispredict_pc;
        else if (m_mode == 1 && ret_valid) fpc = ret_pc;
        else fpc = m_pred;
        if (m_valid) chk("f_pc", bus.f_pc, fpc);
        live   = (m_mode == 0) || (m_mode == 1 && (mispredict || ret_valid));
        valp   = fpc + instr_len(bus.imem_icode);
        st     = exp_stat(bus.imem_err, bus.imem_icode);
        n_pred = m_pred;
        if (live && !f_stall)
            n_pred = (bus.imem_icode == 4'h7 || bus.imem_icode == 4'h8) ? bus.imem_valC : valp;
        n_mode = m_mode;
        if (live && !f_stall && !d_stall)
            n_mode = (bus.imem_icode == 4'h9) ? 1 : (st != 3'd1) ? 2 : 0;
        load_bubble = (m_mode == 2) || (!d_stall && (d_bubble || !live));
        load_fetch  = !load_bubble && !d_stall;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_valid = 1'b1; m_mode = 0; m_pred = '0;
            model_bubble();
        end else if (m_valid) begin
            if (load_bubble) model_bubble();
            else if (load_fetch) begin
                m_icode = bus.imem_icode; m_ifun = bus.imem_ifun; m_ra = bus.imem_rA;
                m_rb = bus.imem_rB; m_valc = bus.imem_valC; m_valp = valp; m_stat = st;
            end
            m_pred = n_pred;
            m_mode = n_mode;
        end
        if (m_valid) begin
            chk("d_icode", 32'(d_icode), 32'(m_icode));
            chk("d_ifun",  32'(d_ifun),  32'(m_ifun));
            chk("d_rA",    32'(d_rA),    32'(m_ra));
            chk("d_rB",    32'(d_rB),    32'(m_rb));
            chk("d_valC",  d_valC, m_valc);
            chk("d_valP",  d_valP, m_valp);
            chk("d_stat",  32'(d_stat), 32'(m_stat));
            chk("f_state", 32'(f_state),
                32'(m_mode == 0 ? ST_RUN : m_mode == 1 ? ST_RET_WAIT : ST_HALTED));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int halt_cnt;
        set_imem(4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 1'b0);
        @(posedge clk);
        #1;

        // Reset
        do_reset();
        chk("rst_f_pc", bus.f_pc, 32'h0);
        chk("rst_d_icode", 32'(d_icode), 32'h1);
        chk("rst_d_rA", 32'(d_rA), 32'hF);
        chk("rst_d_stat", 32'(d_stat), 32'h1);
        chk("rst_state", 32'(f_state), 32'(ST_RUN));

        // Straight-line: irmovl at 0, opl at 6
        set_imem(4'h3, 4'h0, 4'hF, 4'h2, 32'h1234, 1'b0);
        cycle();
        chk("irmovl_icode", 32'(d_icode), 32'h3);
        chk("irmovl_valP", d_valP, 32'h6);
        chk("irmovl_f_pc", bus.f_pc, 32'h6);
        set_imem(4'h6, 4'h0, 4'h1, 4'h2, 32'h0, 1'b0);
        cycle();
        chk("opl_valP", d_valP, 32'h8);

        // Branch: jXX at 0x10 predicts 0x40, then mispredict back to 0x15
        mispredict = 1'b1; mispredict_pc = 32'h10;
        set_imem(4'h7, 4'h1, 4'hF, 4'hF, 32'h40, 1'b0);
        cycle();
        mispredict = 1'b0;
        #1;
        chk("jxx_valP", d_valP, 32'h15);
        chk("jxx_f_pc", bus.f_pc, 32'h40);
        mispredict = 1'b1; mispredict_pc = 32'h15;
        set_imem(4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 1'b0);
        #1;
        chk("mispred_f_pc", bus.f_pc, 32'h15);
        cycle();

        // Return: ret at 0x20, wait three cycles, resume at 0x100
        mispredict_pc = 32'h20;
        set_imem(4'h9, 4'h0, 4'hF, 4'hF, 32'h0, 1'b0);
        cycle();
        mispredict = 1'b0;
        chk("ret_state", 32'(f_state), 32'(ST_RET_WAIT));
        chk("ret_icode", 32'(d_icode), 32'h9);
        set_imem(4'h3, 4'h0, 4'hF, 4'h1, 32'h55, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("retwait_bubble", 32'(d_icode), 32'h1);
            chk("retwait_f_pc", bus.f_pc, 32'h21);
        end
        ret_valid = 1'b1; ret_pc = 32'h100;
        #1;
        chk("ret_f_pc", bus.f_pc, 32'h100);
        cycle();
        ret_valid = 1'b0;
        chk("ret_resume_icode", 32'(d_icode), 32'h3);
        chk("ret_resume_valP", d_valP, 32'h106);
        chk("ret_resume_state", 32'(f_state), 32'(ST_RUN));

        // Halt at 0x30; mispredict pulses must not move f_pc
        mispredict = 1'b1; mispredict_pc = 32'h30;
        set_imem(4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 1'b0);
        cycle();
        mispredict = 1'b0;
        chk("halt_stat", 32'(d_stat), 32'h2);
        chk("halt_state", 32'(f_state), 32'(ST_HALTED));
        set_imem(4'h3, 4'h0, 4'hF, 4'h1, 32'h77, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mispredict = 1'(i % 2 == 0); mispredict_pc = $urandom;
            #1;
            chk("halt_f_pc", bus.f_pc, 32'h31);
            cycle();
            chk("halt_bubble", 32'(d_icode), 32'h1);
        end
        mispredict = 1'b0;

        // Invalid icode and address error
        do_reset();
        set_imem(4'hC, 4'h0, 4'hF, 4'hF, 32'h0, 1'b0);
        cycle();
        chk("ins_stat", 32'(d_stat), 32'h4);
        do_reset();
        set_imem(4'h3, 4'h0, 4'hF, 4'h1, 32'h0, 1'b1);
        cycle();
        chk("adr_stat", 32'(d_stat), 32'h3);

        // Stall and bubble
        do_reset();
        set_imem(4'h3, 4'h0, 4'hF, 4'h2, 32'hABCD, 1'b0);
        cycle();
        f_stall = 1'b1; d_stall = 1'b1;
        set_imem(4'h6, 4'h1, 4'h3, 4'h4, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("stall_f_pc", bus.f_pc, 32'h6);
            chk("stall_icode", 32'(d_icode), 32'h3);
            chk("stall_valC", d_valC, 32'hABCD);
        end
        f_stall = 1'b0; d_bubble = 1'b1;
        cycle();
        chk("stall_over_bubble", 32'(d_icode), 32'h3);
        d_stall = 1'b0;
        cycle();
        chk("bubble_icode", 32'(d_icode), 32'h1);
        chk("bubble_valP", d_valP, 32'h0);
        d_bubble = 1'b0;

        // Randomized traffic
        halt_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 9)
                set_imem(4'($urandom_range(1, 11)), 4'($urandom), 4'($urandom), 4'($urandom),
                         $urandom, 1'($urandom_range(0, 40) == 0));
            else
                set_imem(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), $urandom, 1'b0);
            f_stall       = 1'($urandom_range(0, 6) == 0);
            d_stall       = 1'($urandom_range(0, 6) == 0);
            d_bubble      = 1'($urandom_range(0, 6) == 0);
            mispredict    = 1'($urandom_range(0, 9) == 0);
            mispredict_pc = $urandom;
            ret_valid     = 1'($urandom_range(0, 3) == 0);
            ret_pc        = $urandom;
            halt_cnt      = (m_mode == 2) ? halt_cnt + 1 : 0;
            rst_n         = !(halt_cnt > 3 || $urandom_range(0, 99) == 0);
            cycle();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Pipelined Y86 fetch-stage control. Sits directly upstream of the instruction memory: drives its PC input and consumes the decoded fields it returns (icode, ifun, rA, rB, valC, error flag).
- Holds the F (predicted-PC) register and runs the fetch FSM (RUN / RET_WAIT / HALTED).
- Computes valP and the next predicted PC.
- Writes the F/D pipeline register that feeds decode.

Parameters:
- DATA_WID, 32, address/data width; must equal `DATA_WID; valC occupies DATA_WID/8 bytes.
- RESET_PC, 0, PC loaded at reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- f_stall  in  1  hold F register.
- d_stall  in  1  hold D register.
- d_bubble  in  1  load NOP into D register.
- mispredict  in  1  taken-branch misprediction detected downstream.
- mispredict_pc  in  DATA_WID  fall-through PC to resume at.
- ret_valid  in  1  return address available.
- ret_pc  in  DATA_WID  return address.
- imem_icode  in  4  from instruction memory.
- imem_ifun  in  4  from instruction memory.
- imem_rA  in  4  from instruction memory.
- imem_rB  in  4  from instruction memory.
- imem_valC  in  DATA_WID  from instruction memory.
- imem_err  in  1  fetch address out of range.
- f_pc  out  DATA_WID  PC to instruction memory (combinational).
- d_icode  out  4  D register field.
- d_ifun  out  4  D register field.
- d_rA  out  4  D register field.
- d_rB  out  4  D register field.
- d_valC  out  DATA_WID  D register field.
- d_valP  out  DATA_WID  D register field.
- d_stat  out  3  D register status.
- f_state  out  2  FSM state, for debug.

Behaviour:
- Reset (rst_n low at posedge):
  - predPC=RESET_PC, state=RUN.
  - D register = bubble: icode=1 (NOP), ifun=0, rA=rB=0xF, valC=0, valP=0, stat=AOK(1).
- f_pc, combinational, priority order: mispredict -> mispredict_pc; else ret_valid && state==RET_WAIT -> ret_pc; else predPC.
- Instruction length = 1 + need_regids + need_valC*(DATA_WID/8).
  - need_regids for icodes 2,3,4,5,6,A,B.
  - need_valC for icodes 3,4,5,7,8.
  - valP = f_pc + length, modulo 2^DATA_WID (wraps, no flag).
- Next predPC: icode 7 (JXX) or 8 (CALL) -> imem_valC; otherwise valP.
- Fetch status f_stat:
  - imem_err -> ADR(3).
  - else icode > 0xB -> INS(4).
  - else icode 0 -> HLT(2).
  - else AOK(1).
- FSM:
  - RUN:
    - fetched RET (9) -> RET_WAIT.
    - f_stat != AOK -> HALTED.
    - else stay in RUN.
  - RET_WAIT:
    - D loads bubble every cycle; predPC held.
    - ret_valid -> that cycle's fetch from ret_pc is a normal RUN fetch (D and predPC update, FSM re-evaluated as RUN).
    - mispredict has priority and behaves identically.
  - HALTED:
    - predPC frozen; D loads bubble every cycle.
    - Exits only on reset; stall, bubble, mispredict and ret are ignored.
- F register update:
  - Updates at posedge unless f_stall, or state is RET_WAIT without ret_valid/mispredict, or state is HALTED.
  - On mispredict, loads the prediction computed from mispredict_pc's instruction.
- D register:
  - d_stall -> hold.
  - else d_bubble -> bubble.
  - else fetched fields, valP and f_stat.
  - d_stall && d_bubble -> stall wins.
- FSM transitions are suppressed while f_stall or d_stall is asserted: the instruction is refetched and re-evaluated next cycle.
- One-cycle latency from f_pc to D outputs. No combinational path from imem_* inputs to D outputs.

Decomposition:
- Shared header (head.v) holds:
  - icode constants (HALT..POPL).
  - stat codes (AOK/HLT/ADR/INS).
  - RNONE=0xF.
  - FSM state encodings.
  - bubble field values.
- One natural sub-module: fetch_len_calc. It is combinational: icode and f_pc in, need_regids, need_valC and valP out.

Test Plan (DATA_WID=32):
1. Reset: hold rst_n=0 for 2 cycles, release -> f_pc=0, d_icode=1, d_rA=0xF, d_stat=1, f_state=RUN.
2. Straight-line fetch: irmovl (icode 3) at 0 -> next cycle d_icode=3, d_valP=6, f_pc=6. Then opl (icode 6) at 6 -> d_valP=8.
3. Branch:
   - jXX at 0x10 with valC=0x40 -> d_valP=0x15, f_pc=0x40.
   - Then mispredict=1, mispredict_pc=0x15 -> f_pc=0x15 in the same cycle.
4. Return:
   - ret at 0x20 -> f_state=RET_WAIT, and D shows icode 9.
   - For 3 cycles D is a bubble and f_pc is held.
   - ret_valid with ret_pc=0x100 -> f_pc=0x100 that cycle; next cycle D holds the 0x100 instruction and f_state=RUN.
5. Halt/invalid:
   - halt at 0x30 -> d_stat=2, f_state=HALTED; bubbles follow; f_pc stays frozen despite mispredict pulses.
   - icode 0xC after reset -> d_stat=4. imem_err -> d_stat=3.
6. Stall/bubble:
   - f_stall=d_stall=1 for 2 cycles -> f_pc and all D outputs unchanged.
   - d_stall=d_bubble=1 -> D holds.
   - d_bubble alone -> d_icode=1, d_valP=0.
